alu_ctrl_stage: RTL
===================

Name: alu_ctrl_stage

Overview:
- Decode/issue stage that produces the 4-bit ALU Operation code and operand-select controls from raw RV32I instructions.
- Registers the decoded controls behind a 2-entry skid buffer with valid/ready handshakes on both sides.
- Sits between the fetch/ID path and the EX-stage ALU; supports back-pressure and pipeline flush.

Parameters:
- ADDR_WIDTH, 32, width of the PC tag carried alongside each instruction.
- INSTR_WIDTH, 32, instruction width; fixed at 32 for RV32I.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous pipeline flush; discards all held entries.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept; driven from a register.
- in_instr  in  32  raw instruction.
- in_pc  in  ADDR_WIDTH  PC of the instruction.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  EX stage consumes the entry.
- out_alu_op  out  4  ALU Operation code.
- out_src_b_imm  out  1  1 = ALU SrcB from immediate, 0 = from rs2.
- out_is_branch  out  1  conditional branch.
- out_is_jump  out  1  JAL/JALR.
- out_illegal  out  1  unsupported encoding.
- out_pc  out  ADDR_WIDTH  PC of the presented entry.

Behaviour:
- ALU op codes:
  - AND 0000, OR 0001, ADD 0010, XOR 0011.
  - SLL 0100, SRL 0101, SUB 0110, SRA 0111.
  - EQ 1000, NE 1001, TRUE 1010.
  - LT 1100, GE 1101, LTU 1110, GEU 1111.
- Decode, opcode 0110011 (R-type):
  - f3 000: f7 0000000 ADD, 0100000 SUB.
  - f3 001 SLL, 010 LT, 011 LTU, 100 XOR.
  - f3 101: f7 0000000 SRL, 0100000 SRA.
  - f3 110 OR, 111 AND.
  - Any other f7 is illegal.
  - src_b_imm=0.
- Decode, opcode 0010011 (I-type ALU):
  - Same f3 mapping as R-type; f3 000 is always ADD.
  - Shifts (f3 001/101) check f7 as for R-type; any other f7 is illegal.
  - src_b_imm=1.
- Decode, other opcodes:
  - 0000011 load / 0100011 store: ADD, src_b_imm=1.
  - 0110111 LUI / 0010111 AUIPC: ADD, src_b_imm=1.
  - 1100011 branch: f3 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; f3 010/011 illegal. is_branch=1, src_b_imm=0.
  - 1101111 JAL / 1100111 JALR: TRUE, is_jump=1, src_b_imm=1.
  - Any other opcode: illegal.
- Illegal entries carry alu_op=0000 and branch/jump/imm flags 0.
- Handshake:
  - Accept when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - Output fields stay stable while out_valid && !out_ready.
  - Latency from accept to out_valid is 1 cycle when empty.
  - Throughput is 1 instruction/cycle when out_ready is held high.
- FSM:
  - EMPTY (out_valid=0, in_ready=1): accept -> MAIN.
  - MAIN (out_valid=1, in_ready=1):
    - accept && pop -> MAIN with the new entry.
    - accept && !pop -> FULL, new entry into skid.
    - pop only -> EMPTY.
  - FULL (out_valid=1, in_ready=0): pop -> MAIN, skid entry moves to main; no accept possible.
- Flush:
  - Next state EMPTY, all entries dropped.
  - Flush wins over a simultaneous accept (incoming instruction discarded) and over a pop.
- Reset:
  - State EMPTY; out_valid=0; in_ready=1.
  - All out_* fields 0.
  - Reset overrides flush and handshakes, including mid-stream in FULL.
- Ordering: entries leave in acceptance order; no loss or duplication under any ready pattern.

Decomposition:
- Package alu_ctrl_pkg:
  - typedef enum logic[3:0] alu_op_e with the codes above.
  - RV32I opcode localparams.
  - Packed struct decoded_t {alu_op, src_b_imm, is_branch, is_jump, illegal, pc}.
- Sub-module alu_op_decode: purely combinational instr -> decoded_t, instantiated ahead of the skid buffer.
- Top module holds the FSM plus main/skid registers of decoded_t.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, all out_* 0 during reset and on the first cycle after release.
2. SUB: accept 0x40B50533 (sub a0,a0,a1), out_ready=1 -> next cycle out_valid=1, out_alu_op=0110, src_b_imm=0, illegal=0, out_pc matches.
3. Branch/jump:
   - 0x00B56463 (bltu) -> alu_op=1110, is_branch=1.
   - 0x0000006F (jal) -> alu_op=1010, is_jump=1, src_b_imm=1.
4. Back-pressure: out_ready=0, offer 3 instructions back-to-back -> first two accepted, in_ready=0 from the cycle after the second; raise out_ready -> all three delivered in order, one per cycle, fields stable while stalled.
5. Flush in FULL with in_valid=1 the same cycle -> next cycle out_valid=0, in_ready=1, incoming instruction never appears.
6. Illegal encodings: 0x00000000, and branch with f3=010 (0x00B52463) -> out_illegal=1, alu_op=0000, is_branch=0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types for the RV32I ALU-control issue stage: ALU op codes, opcodes,
// the decoded entry carried through the skid buffer, and the FSM states.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_EQ   = 4'b1000,
    ALU_NE   = 4'b1001,
    ALU_TRUE = 4'b1010,
    ALU_LT   = 4'b1100,
    ALU_GE   = 4'b1101,
    ALU_LTU  = 4'b1110,
    ALU_GEU  = 4'b1111
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // PC width held in the decoded entry; the top's ADDR_WIDTH must match it.
  localparam int PC_W = 32;

  typedef struct packed {
    alu_op_e         alu_op;
    logic            src_b_imm;
    logic            is_branch;
    logic            is_jump;
    logic            illegal;
    logic [PC_W-1:0] pc;
  } decoded_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_MAIN  = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

  // Shared f3 mapping of the R-type and I-type ALU groups.
  function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_LT;
      3'b011:  arith_op = ALU_LTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode of one instruction into the ALU-control entry.
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter int INSTR_WIDTH = 32
) (
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic [PC_W-1:0]        pc,
  output decoded_t               dec
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       shift;
  logic       f7_ok;
  logic       unused_fields;

  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign shift = (f3 == 3'b001) || (f3 == 3'b101);
  // Only ADD/SUB and SRL/SRA have an alternate f7 encoding.
  assign f7_ok = (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    dec     = '0;
    dec.pc  = pc;
    case (opc)
      OPC_OP: begin
        if (f7_ok) dec.alu_op = arith_op(f3, f7 == F7_ALT);
        else       dec.illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        if (shift && !f7_ok) begin
          dec.illegal = 1'b1;
        end else begin
          dec.alu_op    = arith_op(f3, shift && (f7 == F7_ALT));
          dec.src_b_imm = 1'b1;
        end
      end
      OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC: begin
        dec.alu_op    = ALU_ADD;
        dec.src_b_imm = 1'b1;
      end
      OPC_BRANCH: begin
        dec.is_branch = 1'b1;
        case (f3)
          3'b000:  dec.alu_op = ALU_EQ;
          3'b001:  dec.alu_op = ALU_NE;
          3'b100:  dec.alu_op = ALU_LT;
          3'b101:  dec.alu_op = ALU_GE;
          3'b110:  dec.alu_op = ALU_LTU;
          3'b111:  dec.alu_op = ALU_GEU;
          default: begin
            dec.is_branch = 1'b0;
            dec.illegal   = 1'b1;
          end
        endcase
      end
      OPC_JAL, OPC_JALR: begin
        dec.alu_op    = ALU_TRUE;
        dec.is_jump   = 1'b1;
        dec.src_b_imm = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_stage.sv
// Decode/issue stage: decodes RV32I instructions and holds the results in a
// 2-entry skid buffer (main + skid) with valid/ready on both sides.
module alu_ctrl_stage
  import alu_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  input  logic [ADDR_WIDTH-1:0]  in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             out_alu_op,
  output logic                   out_src_b_imm,
  output logic                   out_is_branch,
  output logic                   out_is_jump,
  output logic                   out_illegal,
  output logic [ADDR_WIDTH-1:0]  out_pc
);

  decoded_t dec;
  decoded_t main_q, main_d;
  decoded_t skid_q, skid_d;
  state_e   state_q, state_d;
  logic     in_ready_q, in_ready_d;
  logic     accept, pop;

  alu_op_decode #(.INSTR_WIDTH(INSTR_WIDTH)) u_decode (
    .instr (in_instr),
    .pc    (PC_W'(in_pc)),
    .dec   (dec)
  );

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = in_ready_q;
  assign accept    = in_valid && in_ready_q;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          main_d  = dec;
          state_d = ST_MAIN;
        end
        ST_MAIN: begin
          if (accept && pop) begin
            main_d = dec;
          end else if (accept) begin
            skid_d  = dec;
            state_d = ST_FULL;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: if (pop) begin
          main_d  = skid_q;
          state_d = ST_MAIN;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    // Registered ready: deasserted exactly while both entries are occupied.
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign out_alu_op    = main_q.alu_op;
  assign out_src_b_imm = main_q.src_b_imm;
  assign out_is_branch = main_q.is_branch;
  assign out_is_jump   = main_q.is_jump;
  assign out_illegal   = main_q.illegal;
  assign out_pc        = ADDR_WIDTH'(main_q.pc);

endmodule
